// File: rtl/vibrato_pkg.sv
// Shared types for the time-multiplexed vibrato scheduler.
// Per-voice config, LFO state and one-step result bundles.
`timescale 1ns/1ps
package vibrato_pkg;

    localparam int DEPTH_W = 4;
    localparam int SPEED_W = 8;

    typedef struct packed {
        logic               en;
        logic [DEPTH_W-1:0] depth;
        logic [SPEED_W-1:0] speed;
    } vcfg_t;

    typedef struct packed {
        logic [SPEED_W-1:0] div;
        logic               dir;
        logic [DEPTH_W-1:0] val;
    } vstate_t;

    typedef struct packed {
        vstate_t            nxt;
        logic               load_off;
        logic [DEPTH_W-1:0] off;
    } vstep_t;

endpackage

// File: rtl/vibrato_step_calc.sv
// Combinational next-state of one voice's triangle LFO.
// In: cfg, st, off (current offset). Out: res (next state, offset load).
`timescale 1ns/1ps
module vibrato_step_calc
    import vibrato_pkg::*;
(
    input  vcfg_t              cfg,
    input  vstate_t            st,
    input  logic [DEPTH_W-1:0] off,
    output vstep_t             res
);

    always_comb begin
        res     = '0;
        res.nxt = st;
        if (!cfg.en) begin
            // Disabled: clear everything, report only a real change.
            res.nxt      = '0;
            res.load_off = |off;
            res.off      = '0;
        end else if (st.div != cfg.speed) begin
            res.nxt.div = st.div + 1'b1;
        end else begin
            res.nxt.div  = '0;
            res.load_off = 1'b1;
            res.off      = st.val;
            unique case (1'b1)
                (!st.dir && (st.val < cfg.depth)):
                    res.nxt.val = st.val + 1'b1;
                (!st.dir && (st.val >= cfg.depth)):
                    res.nxt.dir = 1'b1;
                (st.dir && (st.val != '0)):
                    res.nxt.val = st.val - 1'b1;
                default:
                    res.nxt.dir = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/vibrato_scheduler.sv
// Round-robin vibrato engine shared by NUM_VOICES voices.
// Ports: clk, rst (async low), cfg_* write port, vibrato_o, upd_o, upd_voice_o.
`timescale 1ns/1ps
module vibrato_scheduler
    import vibrato_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [VIDX_W-1:0]       cfg_voice,
    input  logic                    cfg_enable,
    input  logic [DEPTH_W-1:0]      cfg_depth,
    input  logic [SPEED_W-1:0]      cfg_speed,
    output logic [4*NUM_VOICES-1:0] vibrato_o,
    output logic                    upd_o,
    output logic [VIDX_W-1:0]       upd_voice_o
);

    logic [VIDX_W-1:0]  slot;
    vcfg_t              cfg_q [NUM_VOICES];
    vstate_t            st_q  [NUM_VOICES];
    logic [DEPTH_W-1:0] off_q [NUM_VOICES];
    vstep_t             res;
    vcfg_t              wr_cfg;
    logic               collide;

    assign wr_cfg  = '{en: cfg_enable, depth: cfg_depth, speed: cfg_speed};
    assign collide = cfg_we && (cfg_voice == slot);

    vibrato_step_calc u_calc (
        .cfg (cfg_q[slot]),
        .st  (st_q[slot]),
        .off (off_q[slot]),
        .res (res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot        <= '0;
            upd_o       <= 1'b0;
            upd_voice_o <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                cfg_q[i] <= '0;
                st_q[i]  <= '0;
                off_q[i] <= '0;
            end
        end else begin
            // Power-of-two voice count: natural wrap.
            slot  <= slot + 1'b1;
            upd_o <= 1'b0;
            // A write to the visited voice discards its step.
            if (!collide) begin
                st_q[slot] <= res.nxt;
                if (res.load_off) begin
                    off_q[slot] <= res.off;
                    upd_o       <= 1'b1;
                    upd_voice_o <= slot;
                end
            end
            if (cfg_we) begin
                cfg_q[cfg_voice] <= wr_cfg;
                st_q[cfg_voice]  <= '0;
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
        assign vibrato_o[4*v +: 4] = off_q[v];
    end

endmodule

// File: tb/tb_vibrato_scheduler.sv
// Self-checking bench for vibrato_scheduler.
// Model: closed-form triangle from visit count since last config write.
`timescale 1ns/1ps
module tb_vibrato_scheduler;

    localparam int NV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic        cfg_enable = 1'b0;
    logic [3:0]  cfg_depth = '0;
    logic [7:0]  cfg_speed = '0;
    logic [15:0] vibrato_o;
    logic        upd_o;
    logic [1:0]  upd_voice_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vibrato_scheduler #(.NUM_VOICES(4), .VIDX_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_enable  (cfg_enable),
        .cfg_depth   (cfg_depth),
        .cfg_speed   (cfg_speed),
        .vibrato_o   (vibrato_o),
        .upd_o       (upd_o),
        .upd_voice_o (upd_voice_o)
    );

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Offset published at step n (0-based) after a config write.
    function automatic int tri_val(int n, int d);
        int p;
        p = n % (2 * (d + 1));
        return (p <= d) ? p : (2 * d + 1 - p);
    endfunction

    // ---------------- behavioural model ----------------
    int m_slot = 0;
    bit m_en  [NV];
    int m_dep [NV];
    int m_spd [NV];
    int m_vis [NV];
    int m_off [NV];
    bit m_upd = 0;
    int m_uv  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_slot = 0;
            m_upd  = 0;
            m_uv   = 0;
            for (int i = 0; i < NV; i++) begin
                m_en[i]  = 0;
                m_dep[i] = 0;
                m_spd[i] = 0;
                m_vis[i] = 0;
                m_off[i] = 0;
            end
        end else begin
            int v;
            m_upd = 0;
            v = m_slot;
            if (!(cfg_we && int'(cfg_voice) == v)) begin
                if (!m_en[v]) begin
                    if (m_off[v] != 0) begin
                        m_upd = 1;
                        m_uv  = v;
                    end
                    m_off[v] = 0;
                end else begin
                    m_vis[v]++;
                    if (m_vis[v] % (m_spd[v] + 1) == 0) begin
                        m_off[v] = tri_val(m_vis[v] / (m_spd[v] + 1) - 1,
                                           m_dep[v]);
                        m_upd = 1;
                        m_uv  = v;
                    end
                end
            end
            if (cfg_we) begin
                m_en[cfg_voice]  = cfg_enable;
                m_dep[cfg_voice] = int'(cfg_depth);
                m_spd[cfg_voice] = int'(cfg_speed);
                m_vis[cfg_voice] = 0;
            end
            m_slot = (m_slot + 1) % NV;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int e;
        e = 0;
        for (int i = 0; i < NV; i++) e += (m_off[i] & 15) << (4 * i);
        chk("vibrato_o", int'(vibrato_o), e);
        chk("upd_o", int'(upd_o), int'(m_upd));
        if (m_upd) chk("upd_voice_o", int'(upd_voice_o), m_uv);
    end

    // ---------------- stimulus ----------------
    task automatic cfg(int v, bit en, int d, int s);
        cfg_we     = 1'b1;
        cfg_voice  = v[1:0];
        cfg_enable = en;
        cfg_depth  = d[3:0];
        cfg_speed  = s[7:0];
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_upd(int v, int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (upd_o && int'(upd_voice_o) == v) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_upd voice %0d: no pulse within %0d cycles",
                     v, budget);
        end
    endtask

    initial begin
        int c;
        bit ok;
        int np;
        int e0 [8] = '{0, 1, 2, 2, 1, 0, 0, 1};
        int e2 [4] = '{0, 1, 1, 0};

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle after reset
        np = 0;
        repeat (16) begin
            @(negedge clk);
            if (upd_o) np++;
        end
        chk("idle_pulses", np, 0);
        chk("idle_vib", int'(vibrato_o), 0);

        // Voice 0: depth 2, speed 0
        cfg(0, 1, 2, 0);
        for (int i = 0; i < 8; i++) begin
            wait_upd(0, 12, c, ok);
            if (ok) begin
                chk("v0_off", int'(vibrato_o[3:0]), e0[i]);
                if (i > 0) chk("v0_period", c, 4);
            end
        end
        cfg(0, 0, 0, 0);
        repeat (8) @(negedge clk);
        chk("v0_cleared", int'(vibrato_o), 0);

        // Voice 2: depth 1, speed 3
        cfg(2, 1, 1, 3);
        for (int i = 0; i < 4; i++) begin
            wait_upd(2, 40, c, ok);
            if (ok) begin
                chk("v2_off", int'(vibrato_o[11:8]), e2[i]);
                chk("v2_others", int'(vibrato_o & 16'hF0FF), 0);
                if (i > 0) chk("v2_period", c, 16);
            end
        end

        // Write voice 1 in its own slot cycle
        for (int k = 0; k < 8; k++) begin
            if (m_slot == 1) break;
            @(negedge clk);
        end
        chk("align_slot1", m_slot, 1);
        cfg(1, 1, 3, 1);
        chk("collide_no_upd", int'(upd_o), 0);
        wait_upd(1, 20, c, ok);
        if (ok) begin
            chk("collide_latency", c, 8);
            chk("v1_first_off", int'(vibrato_o[7:4]), 0);
        end
        cfg(1, 0, 0, 0);
        cfg(2, 0, 0, 0);
        repeat (8) @(negedge clk);

        // Voice 3 ramps to 5 then gets disabled
        cfg(3, 1, 7, 0);
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (vibrato_o[15:12] == 4'd5) begin
                ok = 1;
                break;
            end
        end
        chk("v3_reached5", int'(ok), 1);
        cfg(3, 0, 0, 0);
        wait_upd(3, 8, c, ok);
        if (ok) chk("v3_disabled_off", int'(vibrato_o[15:12]), 0);

        // Reset mid-ramp with all voices active
        cfg(0, 1, 3, 0);
        cfg(1, 1, 5, 1);
        cfg(2, 1, 7, 0);
        cfg(3, 1, 9, 2);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_vib", int'(vibrato_o), 0);
        chk("rst_async_upd", int'(upd_o), 0);
        chk("rst_async_uv", int'(upd_voice_o), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        np = 0;
        repeat (20) begin
            @(negedge clk);
            if (upd_o) np++;
        end
        chk("post_rst_pulses", np, 0);
        chk("post_rst_vib", int'(vibrato_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vibrato_scheduler.md
# vibrato_scheduler

Time-multiplexed vibrato controller that shares one vibrato step engine round-robin across `NUM_VOICES` tone voices. It holds each voice's configuration (enable, depth, speed) and LFO state (divider, direction, value), and visits one voice per clock. It publishes a registered 4-bit pitch offset per voice plus an update strobe. It sits between the register interface and the per-voice oscillators, replacing one vibrato instance per voice.

## Interface
- `NUM_VOICES`, 4, number of voices served; power of two, 2..16
- `VIDX_W`, 2, voice index width, equal to log2(`NUM_VOICES`)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  config write strobe, one cycle
- `cfg_voice`  in  `VIDX_W`  target voice of the config write
- `cfg_enable`  in  1  vibrato enable for the target voice
- `cfg_depth`  in  4  modulation depth, the peak offset
- `cfg_speed`  in  8  divider terminal count
- `vibrato_o`  out  4*`NUM_VOICES`  packed offsets; voice v occupies bits [4v+3:4v]
- `upd_o`  out  1  one-cycle pulse: an offset register was written this cycle
- `upd_voice_o`  out  `VIDX_W`  voice index qualified by `upd_o`

## Operation
- Slot counter `slot` runs 0..`NUM_VOICES`-1, advances every clock and wraps to 0. It is never stalled.
- Per-voice storage:
  - config: `en`, `depth[3:0]`, `speed[7:0]`
  - state: `div[7:0]`, `dir` (0 = rising, 1 = falling), `val[3:0]`
  - output: `off[3:0]`
- Processing voice v when `slot` == v:
  - `en`=0: clear `div`, `dir`, `val` and `off` to 0. `upd_o` pulses only if `off` was nonzero.
  - `en`=1 and `div` != `speed`: increment `div`.
  - `en`=1 and `div` == `speed`: set `div`=0 and take one step:
    - rising with `val` < `depth`: `val`+1
    - rising with `val` >= `depth`: set `dir`=1; `val` holds
    - falling with `val` > 0: `val`-1
    - falling with `val` == 0: set `dir`=0; `val` holds
  - On a step, load `off` with the pre-step `val` and pulse `upd_o`/`upd_voice_o`=v.
- Waveform: triangle 0..depth..0. Each turnaround repeats its endpoint value for one extra step.
- `depth`=0: `off` stays 0; `dir` toggles every step.
- Config write: on `cfg_we`, latch `en`/`depth`/`speed` for `cfg_voice`, and clear that voice's `div`, `dir`, `val`. `off` is not touched; it is cleared by the disable path or overwritten by the next step.
- Write and slot collision (`cfg_voice` == `slot` with `cfg_we`): the write wins. The slot's step is discarded, the new config and cleared state are stored, and `upd_o` stays low.
- Lowering `depth` below the current `val`: the rising branch flips `dir`, then the voice descends normally.
- Arithmetic is unsigned. `val` never exceeds max(`depth`, its value at the config write); no wrap is possible. `div` compares for equality only, so `speed`=255 gives 256 visits per step.

## Timing
- Reset: `slot`, all config, state and `off` are 0; `vibrato_o`=0, `upd_o`=0, `upd_voice_o`=0.
- Reset is asynchronous on assert; no output glitch occurs after release.
- Each voice is visited once every `NUM_VOICES` clocks.
- Step period = `NUM_VOICES`*(`speed`+1) clocks.
- `vibrato_o`, `upd_o` and `upd_voice_o` are registered. They change at the same edge that processes the slot, giving 1 cycle latency from slot to output.
- A config write is stored at the edge where `cfg_we` is sampled. It first affects the voice's next visit; if that is the same edge as the voice's slot, the write wins as stated above.
- Reset mid-operation: everything returns to reset values immediately; no partial step is retained.

## Structure
- Package `vibrato_pkg`:
  - `DEPTH_W`=4, `SPEED_W`=8
  - voice config struct: en, depth, speed
  - voice state struct: div, dir, val
  - step-result struct: next state, load_off, off value
- Sub-module `vibrato_step_calc`: purely combinational next-state function of one voice, taking config + state and returning the step result. The scheduler owns the slot counter, storage arrays, write arbitration and output registers.

## Test plan
- Reset then idle for 16 clocks: `vibrato_o`=0 and no `upd_o` pulse.
- Voice 0 set to en=1, depth=2, speed=0: `off0` sequence is 0,1,2,2,1,0,0,1… with one update every 4 clocks. `upd_voice_o`=0 on each pulse.
- Voice 2 set to speed=3, depth=1: updates arrive every 16 clocks. Voices 0, 1 and 3 stay at 0.
- Write voice 1 in the exact cycle its slot is processed: no `upd_o` that cycle; the first step occurs `NUM_VOICES`*(speed+1) clocks later.
- Voice 3 reaches `off3`=5, then a write sets en=0: at its next visit `off3` becomes 0 and `upd_o` pulses with `upd_voice_o`=3.
- Assert `rst` low mid-ramp with all four voices active: all outputs are 0 during reset. After release, voices stay silent until reconfigured.
